// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard command/response codes, sequencer states and the
// per-step command byte lookup used by the init controller.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR0  = 8'hFC;
    localparam logic [7:0] RSP_BAT_ERR1  = 8'hFD;

    typedef enum logic [2:0] {
        SEND,
        WAIT_ACK,
        WAIT_BAT,
        IDLE,
        FAIL
    } state_t;

    // Steps 0-3 form the init sequence, steps 4-5 the LED update.
    function automatic logic [7:0] stepByte(input logic [2:0] step,
                                            input logic [7:0] typematicArg,
                                            input logic [2:0] leds);
        logic [7:0] result;
        result = 8'h00;
        case (step)
            3'd0:    result = CMD_RESET;
            3'd1:    result = CMD_TYPEMATIC;
            3'd2:    result = typematicArg;
            3'd3:    result = CMD_ENABLE;
            3'd4:    result = CMD_SET_LEDS;
            3'd5:    result = {5'b00000, leds};
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_kbd_init_ctrl_ack_timer.sv
// Loadable down-counter that reports expiry once it has counted down to zero;
// it parks at zero until the next load.
module ps2_ack_timer #(
    parameter int counterBits = 22
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [counterBits-1:0] i_loadValue,
    output logic                   o_expired
);

    logic [counterBits-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - counterBits'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/ps2_kbd_init_ctrl.sv
// Host-side PS/2 keyboard sequencer: runs the reset/BAT/typematic/enable init
// sequence, then services LED update requests, with resend and timeout handling.
module ps2_kbd_init_ctrl
    import ps2_pkg::*;
#(
    parameter int         counterBits = 22,
    parameter int         ackTimeout  = 20000,
    parameter int         batTimeout  = 3000000,
    parameter int         maxRetries  = 3,
    parameter logic [7:0] typematic   = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxReady,
    input  logic       txReady,
    input  logic [2:0] ledState,
    input  logic       ledUpdate,
    output logic [7:0] txData,
    output logic       txLoad,
    output logic       busy,
    output logic       ready,
    output logic       fail
);

    localparam int RetryBits = (maxRetries < 2) ? 1 : $clog2(maxRetries + 1);

    state_t                 r_state;
    logic [2:0]             r_step;
    logic [RetryBits-1:0]   r_retries;
    logic                   r_ledPending;
    logic                   r_rxReadyPrev;
    logic [7:0]             r_txData;
    logic                   r_txLoad;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_fail;

    logic                   w_rxNew;
    logic                   w_timerExpired;
    logic                   w_timerLoad;
    logic [counterBits-1:0] w_timerValue;
    logic                   w_resend;

    assign w_rxNew = rxReady & ~r_rxReadyPrev;

    ps2_ack_timer #(.counterBits(counterBits)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timerLoad),
        .i_loadValue(w_timerValue),
        .o_expired  (w_timerExpired)
    );

    // A freshly arrived byte always takes precedence over a timer expiry.
    always_comb begin
        w_resend     = 1'b0;
        w_timerLoad  = 1'b0;
        w_timerValue = counterBits'(ackTimeout);
        case (r_state)
            SEND: w_timerLoad = txReady;
            WAIT_ACK: begin
                if (w_rxNew) begin
                    if (rxData == RSP_RESEND) begin
                        w_resend = 1'b1;
                    end else if (rxData == RSP_ACK && r_step == 3'd0) begin
                        w_timerLoad  = 1'b1;
                        w_timerValue = counterBits'(batTimeout);
                    end
                end else begin
                    w_resend = w_timerExpired;
                end
            end
            WAIT_BAT: w_resend = !w_rxNew && w_timerExpired;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= SEND;
            r_step        <= 3'd0;
            r_retries     <= '0;
            r_ledPending  <= 1'b0;
            r_rxReadyPrev <= 1'b0;
            r_txData      <= 8'h00;
            r_txLoad      <= 1'b0;
            r_busy        <= 1'b1;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_rxReadyPrev <= rxReady;
            r_txLoad      <= 1'b0;
            if (ledUpdate && r_state != IDLE) begin
                r_ledPending <= 1'b1;
            end
            if (w_resend) begin
                if (r_retries == RetryBits'(maxRetries)) begin
                    r_state <= FAIL;
                    r_busy  <= 1'b0;
                    r_fail  <= 1'b1;
                end else begin
                    r_retries <= r_retries + RetryBits'(1);
                    r_state   <= SEND;
                end
            end else begin
                case (r_state)
                    SEND: begin
                        if (txReady) begin
                            r_txData <= stepByte(r_step, typematic, ledState);
                            r_txLoad <= 1'b1;
                            r_state  <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (w_rxNew && rxData == RSP_ACK) begin
                            r_retries <= '0;
                            if (r_step == 3'd0) begin
                                r_state <= WAIT_BAT;
                            end else if (r_step == 3'd3 || r_step == 3'd5) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b1;
                            end else begin
                                r_step  <= r_step + 3'd1;
                                r_state <= SEND;
                            end
                        end
                    end
                    WAIT_BAT: begin
                        if (w_rxNew) begin
                            if (rxData == RSP_BAT_OK) begin
                                r_step  <= 3'd1;
                                r_state <= SEND;
                            end else if (rxData == RSP_BAT_ERR0 || rxData == RSP_BAT_ERR1) begin
                                r_state <= FAIL;
                                r_busy  <= 1'b0;
                                r_fail  <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        if (ledUpdate || r_ledPending) begin
                            r_step       <= 3'd4;
                            r_state      <= SEND;
                            r_ledPending <= 1'b0;
                            r_busy       <= 1'b1;
                            r_ready      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign txData = r_txData;
    assign txLoad = r_txLoad;
    assign busy   = r_busy;
    assign ready  = r_ready;
    assign fail   = r_fail;

endmodule

// File: tb/tb_ps2_kbd_init_ctrl.sv
// Self-checking bench for ps2_kbd_init_ctrl: a randomized keyboard responder
// with a byte-sequence reference model of the init and LED update protocol.
module tb_ps2_kbd_init_ctrl;

    localparam int         ACK_TO = 40;
    localparam int         BAT_TO = 120;
    localparam int         MAXR   = 3;
    localparam logic [7:0] TYP    = 8'h20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] rxData    = 8'h00;
    logic       rxReady   = 1'b0;
    logic       txReady   = 1'b1;
    logic [2:0] ledState  = 3'b000;
    logic       ledUpdate = 1'b0;
    logic [7:0] txData;
    logic       txLoad;
    logic       busy;
    logic       ready;
    logic       fail;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] txLog[$];
    int         txCyc[$];
    logic [7:0] expQ[$];
    bit         rdyRand = 1'b0;

    ps2_kbd_init_ctrl #(
        .counterBits(22),
        .ackTimeout (ACK_TO),
        .batTimeout (BAT_TO),
        .maxRetries (MAXR),
        .typematic  (TYP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxData   (rxData),
        .rxReady  (rxReady),
        .txReady  (txReady),
        .ledState (ledState),
        .ledUpdate(ledUpdate),
        .txData   (txData),
        .txLoad   (txLoad),
        .busy     (busy),
        .ready    (ready),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every transmitted byte is logged with its cycle stamp.
    always @(negedge clk) begin
        if (reset && txLoad) begin
            txLog.push_back(txData);
            txCyc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] init_byte(input int s);
        case (s)
            0:       return 8'hFF;
            1:       return 8'hF3;
            2:       return TYP;
            default: return 8'hF4;
        endcase
    endfunction

    // Each init step goes out once plus once per FE, up to MAXR resends;
    // one FE beyond that ends the sequence in failure.
    function automatic bit model_init(input int fe[4]);
        int sends;
        expQ.delete();
        for (int s = 0; s < 4; s++) begin
            sends = (fe[s] > MAXR) ? MAXR + 1 : fe[s] + 1;
            for (int n = 0; n < sends; n++) expQ.push_back(init_byte(s));
            if (fe[s] > MAXR) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] noise_byte();
        return 8'($urandom_range(0, 159));
    endfunction

    task automatic apply_reset(input int n);
        reset   = 1'b0;
        txReady = 1'b1;
        repeat (n) @(negedge clk);
        txLog.delete();
        txCyc.delete();
        reset = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] v, input int maxDelay);
        repeat ($urandom_range(0, maxDelay)) @(negedge clk);
        rxData  = v;
        rxReady = 1'b1;
        repeat (2) @(negedge clk);
        rxReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_led(input logic [2:0] v);
        ledState  = v;
        ledUpdate = 1'b1;
        @(negedge clk);
        ledUpdate = 1'b0;
    endtask

    task automatic get_tx(output logic [7:0] b, output int stamp, output bit got);
        got   = 1'b0;
        b     = 8'hxx;
        stamp = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            if (txLog.size() != 0) begin
                b     = txLog.pop_front();
                stamp = txCyc.pop_front();
                got   = 1'b1;
            end else begin
                txReady = rdyRand ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clk);
                #1;
            end
        end
        txReady = 1'b1;
    endtask

    task automatic drive_init();
        logic [7:0] b;
        int         st;
        bit         got;
        for (int i = 0; i < 4; i++) begin
            get_tx(b, st, got);
            send_rx(8'hFA, 2);
            if (i == 0) send_rx(8'hAA, 2);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (txData !== 8'h00) begin bad++; $display("[TB] FAIL reset_txData: got %h want 00", txData); end
        total++; if (txLoad !== 1'b0) begin bad++; $display("[TB] FAIL reset_txLoad: got %b want 0", txLoad); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        total++; if (fail !== 1'b0) begin bad++; $display("[TB] FAIL reset_fail: got %b want 0", fail); end
        txReady = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (txLoad !== 1'b1 || txData !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL first_load: got load=%b data=%h want load=1 data=ff", txLoad, txData);
        end
    endtask

    task automatic test_init_sequences;
        int         fe[4];
        bit         willFail;
        logic [7:0] b;
        int         st;
        bit         got;
        int         s;
        int         c;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) fe[i] = 0;
            if (k == 1) fe[1] = 2;
            else if (k == 2 || k == 3) for (int i = 0; i < 4; i++) fe[i] = int'($urandom_range(0, MAXR));
            else if (k == 4) fe[$urandom_range(0, 3)] = MAXR + 1;
            rdyRand  = (k == 3);
            willFail = model_init(fe);
            apply_reset(2);
            s = 0;
            c = 0;
            for (int i = 0; i < expQ.size(); i++) begin
                get_tx(b, st, got);
                total++;
                if (!got || b !== expQ[i]) begin
                    bad++;
                    $display("[TB] FAIL init%0d_byte%0d: got %h want %h", k, i, b, expQ[i]);
                end
                total++;
                if (busy !== 1'b1) begin bad++; $display("[TB] FAIL init%0d_busy%0d: got %b want 1", k, i, busy); end
                if ($urandom_range(0, 2) == 0) send_rx(noise_byte(), 3);
                if (c < fe[s]) begin
                    send_rx(8'hFE, 3);
                    c++;
                end else begin
                    send_rx(8'hFA, 3);
                    if (s == 0) begin
                        if ($urandom_range(0, 1) == 0) send_rx(noise_byte(), 5);
                        send_rx(8'hAA, 5);
                    end
                    s++;
                    c = 0;
                end
            end
            repeat (3) @(negedge clk);
            total++; if (fail !== willFail) begin bad++; $display("[TB] FAIL init%0d_fail: got %b want %b", k, fail, willFail); end
            total++; if (ready !== logic'(!willFail)) begin bad++; $display("[TB] FAIL init%0d_ready: got %b want %b", k, ready, !willFail); end
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL init%0d_busy_end: got %b want 0", k, busy); end
            repeat (ACK_TO + 10) @(negedge clk);
            total++;
            if (txLog.size() != 0) begin
                bad++;
                $display("[TB] FAIL init%0d_extra_tx: got %0d bytes want 0", k, txLog.size());
            end
        end
        rdyRand = 1'b0;
    endtask

    task automatic test_led_update;
        logic [7:0] b;
        int         st;
        bit         got;
        logic [2:0] led;
        apply_reset(2);
        drive_init();
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL led_pre_ready: got %b want 1", ready); end
        for (int it = 0; it < 4; it++) begin
            led = (it == 0) ? 3'b101 : 3'($urandom_range(0, 7));
            pulse_led(led);
            get_tx(b, st, got);
            total++; if (!got || b !== 8'hED) begin bad++; $display("[TB] FAIL led%0d_cmd: got %h want ed", it, b); end
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL led%0d_busy: got %b want 1", it, busy); end
            if (it >= 2) begin
                led      = 3'($urandom_range(0, 7));
                ledState = led;
            end
            send_rx(8'hFA, 3);
            get_tx(b, st, got);
            total++; if (!got || b !== {5'b00000, led}) begin bad++; $display("[TB] FAIL led%0d_arg: got %h want %h", it, b, {5'b00000, led}); end
            total++; if (busy !== 1'b1 || ready !== 1'b0) begin bad++; $display("[TB] FAIL led%0d_busy2: got busy=%b ready=%b want 1/0", it, busy, ready); end
            send_rx(8'hFA, 3);
            @(negedge clk);
            total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL led%0d_idle: got ready=%b busy=%b want 1/0", it, ready, busy); end
        end
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        int         st;
        int         prev;
        bit         got;
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            get_tx(b, st, got);
            send_rx(8'hFA, 2);
            if (i == 0) send_rx(8'hAA, 2);
        end
        get_tx(b, prev, got);
        total++; if (!got || b !== 8'hF4) begin bad++; $display("[TB] FAIL tmo_first: got %h want f4", b); end
        for (int k = 1; k <= MAXR; k++) begin
            get_tx(b, st, got);
            total++; if (!got || b !== 8'hF4) begin bad++; $display("[TB] FAIL tmo_resend%0d: got %h want f4", k, b); end
            total++;
            if (st - prev < ACK_TO || st - prev > ACK_TO + 3) begin
                bad++;
                $display("[TB] FAIL tmo_period%0d: got %0d cycles want %0d..%0d", k, st - prev, ACK_TO, ACK_TO + 3);
            end
            prev = st;
        end
        repeat (ACK_TO + 10) @(negedge clk);
        total++; if (fail !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL tmo_end: got fail=%b ready=%b busy=%b want 1/0/0", fail, ready, busy); end
        total++; if (txLog.size() != 0) begin bad++; $display("[TB] FAIL tmo_extra_tx: got %0d bytes want 0", txLog.size()); end
    endtask

    task automatic test_bat_fail;
        logic [7:0] b;
        int         st0;
        int         st1;
        bit         got;
        apply_reset(2);
        get_tx(b, st0, got);
        total++; if (!got || b !== 8'hFF) begin bad++; $display("[TB] FAIL bat_ff: got %h want ff", b); end
        send_rx(8'hFA, 2);
        get_tx(b, st1, got);
        total++; if (!got || b !== 8'hFF) begin bad++; $display("[TB] FAIL bat_resend: got %h want ff", b); end
        total++;
        if (st1 - st0 < BAT_TO || st1 - st0 > BAT_TO + 15) begin
            bad++;
            $display("[TB] FAIL bat_period: got %0d cycles want %0d..%0d", st1 - st0, BAT_TO, BAT_TO + 15);
        end
        send_rx(8'hFA, 2);
        send_rx(($urandom_range(0, 1) == 0) ? 8'hFC : 8'hFD, 4);
        repeat (2) @(negedge clk);
        total++; if (fail !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bat_end: got fail=%b ready=%b busy=%b want 1/0/0", fail, ready, busy); end
        pulse_led(3'b111);
        repeat (ACK_TO + 10) @(negedge clk);
        total++; if (txLog.size() != 0 || fail !== 1'b1) begin bad++; $display("[TB] FAIL bat_sticky: got %0d bytes fail=%b want 0 bytes fail=1", txLog.size(), fail); end
    endtask

    task automatic test_coalesce;
        logic [7:0] b;
        int         st;
        bit         got;
        logic [2:0] led;
        apply_reset(2);
        rdyRand = 1'b1;
        led     = 3'b000;
        for (int i = 0; i < 4; i++) begin
            get_tx(b, st, got);
            total++; if (!got || b !== init_byte(i)) begin bad++; $display("[TB] FAIL coal_init%0d: got %h want %h", i, b, init_byte(i)); end
            if (i < 3) begin
                led = 3'($urandom_range(0, 7));
                pulse_led(led);
            end
            send_rx(8'hFA, 2);
            if (i == 0) send_rx(8'hAA, 2);
        end
        get_tx(b, st, got);
        total++; if (!got || b !== 8'hED) begin bad++; $display("[TB] FAIL coal_cmd: got %h want ed", b); end
        send_rx(8'hFA, 2);
        get_tx(b, st, got);
        total++; if (!got || b !== {5'b00000, led}) begin bad++; $display("[TB] FAIL coal_arg: got %h want %h", b, {5'b00000, led}); end
        send_rx(8'hFA, 2);
        repeat (ACK_TO + 10) @(negedge clk);
        total++; if (txLog.size() != 0) begin bad++; $display("[TB] FAIL coal_extra_tx: got %0d bytes want 0", txLog.size()); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL coal_ready: got %b want 1", ready); end
        rdyRand = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        int         st;
        int         t0;
        bit         got;
        logic [2:0] led1;
        logic [2:0] led2;
        apply_reset(2);
        drive_init();
        led1 = 3'($urandom_range(0, 7));
        pulse_led(led1);
        get_tx(b, st, got);
        total++; if (!got || b !== 8'hED) begin bad++; $display("[TB] FAIL b2b_cmd1: got %h want ed", b); end
        send_rx(8'hFA, 2);
        get_tx(b, st, got);
        total++; if (!got || b !== {5'b00000, led1}) begin bad++; $display("[TB] FAIL b2b_arg1: got %h want %h", b, {5'b00000, led1}); end
        led2 = 3'($urandom_range(0, 7));
        pulse_led(led2);
        t0 = cyc;
        send_rx(8'hFA, 0);
        get_tx(b, st, got);
        total++; if (!got || b !== 8'hED) begin bad++; $display("[TB] FAIL b2b_cmd2: got %h want ed", b); end
        total++; if (st - t0 > 4) begin bad++; $display("[TB] FAIL b2b_latency: got %0d cycles want <=4", st - t0); end
        send_rx(8'hFA, 2);
        get_tx(b, st, got);
        total++; if (!got || b !== {5'b00000, led2}) begin bad++; $display("[TB] FAIL b2b_arg2: got %h want %h", b, {5'b00000, led2}); end
        send_rx(8'hFA, 2);
        @(negedge clk);
        total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got ready=%b busy=%b want 1/0", ready, busy); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int         st;
        bit         got;
        for (int r = 0; r < 2; r++) begin
            apply_reset(2);
            get_tx(b, st, got);
            send_rx(8'hFA, 2);
            send_rx(8'hAA, 2);
            get_tx(b, st, got);
            total++; if (!got || b !== 8'hF3) begin bad++; $display("[TB] FAIL rst%0d_f3: got %h want f3", r, b); end
            if (r == 0) repeat ($urandom_range(1, 10)) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            total++; if (busy !== 1'b1 || ready !== 1'b0 || txLoad !== 1'b0) begin bad++; $display("[TB] FAIL rst%0d_state: got busy=%b ready=%b load=%b want 1/0/0", r, busy, ready, txLoad); end
            txLog.delete();
            txCyc.delete();
            reset = 1'b1;
            get_tx(b, st, got);
            total++; if (!got || b !== 8'hFF) begin bad++; $display("[TB] FAIL rst%0d_restart: got %h want ff", r, b); end
        end
    endtask

    initial begin
        test_reset();
        test_init_sequences();
        test_led_update();
        test_timeout();
        test_bat_fail();
        test_coalesce();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_init_ctrl.md
# ps2_kbd_init_ctrl

Host-side command sequencer for the PS/2 keyboard link. After reset it puts the keyboard through a full init sequence: reset, self-test (BAT) check, typematic setup and enable scanning. It then stays idle and services LED update requests. It drives the PS/2 host transmitter, and consumes receiver bytes only while a command is outstanding. `busy` tells the scan-code decoder to ignore bytes during that time.

## Interface

Parameters:
- counterBits, 22: width of the timeout counter
- ackTimeout, 20000: cycles to wait for an ACK/RESEND after each `txLoad`
- batTimeout, 3000000: cycles to wait for the BAT result after the ACK to FF
- maxRetries, 3: resends allowed per byte before failing
- typematic, 8'h20: argument byte sent after F3

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low (0 = reset)
- rxData  in  8  last received byte from the PS/2 receiver
- rxReady  in  1  receiver data-ready level; a rising edge means rxData holds a new byte
- txReady  in  1  host transmitter idle, can accept a byte
- ledState  in  3  {caps, num, scroll}
- ledUpdate  in  1  one-cycle request to send ledState
- txData  out  8  byte to transmit
- txLoad  out  1  one-cycle load strobe to the transmitter
- busy  out  1  command or init in progress
- ready  out  1  init complete, controller idle
- fail  out  1  sticky failure flag, cleared only by reset

## Operation

- Byte list: step0 FF, step1 F3, step2 typematic, step3 F4, step4 ED, step5 {5'b0, ledState}.
- Init runs steps 0–3; an LED update runs steps 4–5.
- SEND state:
  - Wait for txReady=1.
  - Drive txData = byte for the current step and pulse txLoad for one cycle.
  - Load the timer with ackTimeout and go to WAIT_ACK.
- WAIT_ACK, new byte FA:
  - After step0: go to WAIT_BAT with timer = batTimeout.
  - After steps 1, 2 and 4: advance the step and go to SEND.
  - After steps 3 and 5: go to IDLE.
  - The retry count clears on every FA.
- WAIT_ACK, new byte FE: resend the same step and increment the retry count.
- WAIT_ACK, timer expires: same as FE.
- WAIT_ACK, any other byte: ignored, keep waiting.
- WAIT_BAT:
  - AA: go to step1, SEND.
  - FC or FD: go to FAIL.
  - Timer expires: resend step0 and increment the retry count.
  - Any other byte: ignored.
- Retry limit: a resend when the retry count already equals maxRetries goes to FAIL instead.
- IDLE:
  - ready=1, busy=0.
  - A pending LED request moves to step4, SEND, and clears the pending flag.
  - Bytes received in IDLE are not consumed.
- FAIL: fail=1, busy=0, ready=0. The block stays here until reset.
- ledUpdate while not in IDLE sets the pending flag. Multiple requests coalesce into one. ledState is sampled at the step5 load, so the newest value is always the one sent.

## Timing

- Reset values: txData=0, txLoad=0, busy=1, ready=0, fail=0. Internally: step=0, retries=0, pending=0, state=SEND.
- First txLoad of FF comes in the first cycle after reset deasserts with txReady=1.
- Rising edge of rxReady is detected against a registered copy, giving 1 cycle latency. The state changes on the cycle after the edge.
- When FA arrives mid-sequence, the next txLoad comes 1 cycle after the state change, provided txReady=1.
- Timeout fires when the counter reaches 0. If a byte edge and expiry happen in the same cycle, the byte wins.
- ledUpdate in the same cycle that IDLE is entered is serviced immediately on the next cycle.
- Asserting reset at any point, including mid-transmit, aborts everything and restarts from step0.
- busy is high in SEND, WAIT_ACK and WAIT_BAT. ready and busy are mutually exclusive.

## Structure

- Shared package ps2_pkg holds:
  - command/response constants: FF, F3, F4, ED, FA, FE, AA, FC, FD
  - the state enum: SEND, WAIT_ACK, WAIT_BAT, IDLE, FAIL
- One sub-module, ps2_ack_timer: loadable down-counter (counterBits wide) with load value, load strobe and expired output.

## Test plan

- Normal init:
  - Model replies FA to FF, then AA, then FA to F3, 20 and F4.
  - txData sequence FF, F3, 20, F4; ready=1 after the last FA; fail=0.
- LED update:
  - In IDLE, pulse ledUpdate with ledState=3'b101; model FA twice.
  - ED then 05 transmitted; busy high throughout; back to IDLE.
- Resend and retry limit:
  - Model answers F3 with FE twice, then FA.
  - F3 transmitted 3 times; init completes.
  - A separate run answers FE 4 times: fail=1 after the 4th FE, no further txLoad.
- Timeout:
  - Model never answers F4.
  - F4 resent every ackTimeout cycles, maxRetries resends, then fail=1.
- BAT failure: model replies FC after the FA to FF → fail=1, ready=0.
- Coalescing and reset:
  - Pulse ledUpdate 3 times during init: exactly one ED/LED pair follows the F4 ACK.
  - Assert reset mid-WAIT_ACK: the next transmitted byte is FF.
